// File: rtl/als_pkg.sv
// Shared frame layout and sequencer state encoding for the Pmod ALS sample path.
package als_pkg;
   localparam int DATA_MSB  = 12;
   localparam int DATA_LSB  = 5;
   localparam int LEAD_MSB  = 15;
   localparam int LEAD_LSB  = 13;
   localparam int TRAIL_MSB = 4;

   // Raw 16-bit frame as shifted in: leading zeros, 8-bit light value, trailing zeros.
   typedef struct packed {
      logic [LEAD_MSB-LEAD_LSB:0] lead;
      logic [DATA_MSB-DATA_LSB:0] data;
      logic [TRAIL_MSB:0]         trail;
   } frame_t;

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
endpackage

// File: rtl/als_period_timer.sv
// Free-running period counter that raises tick in its wrap cycle while enabled.
// Latency: tick is combinational from the registered count.
// Backpressure: none; disabling holds the count at zero.
module als_period_timer #(
   parameter int PERIOD_CYCLES = 5000000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);
   localparam int CW = $clog2(PERIOD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || !enable)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + CW'(1);
   end

   assign tick = enable && (count == LAST);
endmodule

// File: rtl/als_sample_sequencer.sv
// Periodic ALS conversion scheduler: requests frames, times them out, validates and averages samples.
// Latency: spi_start one cycle after tick; sample/average/frame_error one cycle after spi_done.
// Backpressure: spi_busy defers spi_start; ticks arriving while a request is pending are dropped.
module als_sample_sequencer
   import als_pkg::*;
#(
   parameter int PERIOD_CYCLES  = 5000000,
   parameter int AVG_LOG2       = 3,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear_error,
   output logic        spi_start,
   input  logic        spi_busy,
   input  logic        spi_done,
   input  logic [15:0] spi_frame,
   output logic [7:0]  sample,
   output logic        sample_valid,
   output logic [7:0]  average,
   output logic        average_valid,
   output logic        frame_error,
   output logic        timeout_error,
   output logic        overrun
);
   localparam int AW = 8 + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [NW-1:0] BLOCK  = NW'(1 << AVG_LOG2);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic          tick;
   logic [TW-1:0] wait_cnt;
   logic [AW-1:0] acc;
   logic [NW-1:0] cnt;
   frame_t        frame;
   logic [AW-1:0] sum_next;
   logic [NW-1:0] cnt_next;
   logic          frame_ok;
   logic          tick_dropped;
   logic          timeout_hit;

   als_period_timer #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .tick  (tick)
   );

   assign frame        = spi_frame;
   assign frame_ok     = (frame.lead == '0) && (frame.trail == '0);
   assign sum_next     = acc + AW'(frame.data);
   assign cnt_next     = cnt + NW'(1);
   assign tick_dropped = tick && (state != IDLE);
   assign timeout_hit  = (state == WAIT) && !spi_done && (wait_cnt == T_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         acc           <= '0;
         cnt           <= '0;
         spi_start     <= 1'b0;
         sample        <= '0;
         sample_valid  <= 1'b0;
         average       <= '0;
         average_valid <= 1'b0;
         frame_error   <= 1'b0;
         timeout_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         spi_start     <= 1'b0;
         sample_valid  <= 1'b0;
         average_valid <= 1'b0;
         frame_error   <= 1'b0;
         // A set condition in the same cycle as clear_error keeps the flag high.
         overrun       <= (overrun && !clear_error) || tick_dropped;
         timeout_error <= (timeout_error && !clear_error) || timeout_hit;
         case (state)
            IDLE: begin
               if (tick) begin
                  state     <= START;
                  spi_start <= !spi_busy;
               end
            end
            START: begin
               // Once the pulse is out a frame is in flight, so WAIT regardless of enable.
               if (spi_start) begin
                  state    <= WAIT;
                  wait_cnt <= '0;
               end else if (!enable) begin
                  state <= IDLE;
               end else if (!spi_busy) begin
                  spi_start <= 1'b1;
               end
            end
            WAIT: begin
               if (spi_done) begin
                  state <= IDLE;
                  if (frame_ok) begin
                     sample       <= frame.data;
                     sample_valid <= 1'b1;
                     if (cnt_next == BLOCK) begin
                        average       <= sum_next[AVG_LOG2 +: 8];
                        average_valid <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                     end else begin
                        acc <= sum_next;
                        cnt <= cnt_next;
                     end
                  end else begin
                     frame_error <= 1'b1;
                  end
               end else if (wait_cnt == T_LAST) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_als_sample_sequencer.sv
// Directed bench for als_sample_sequencer with PERIOD=100, AVG_LOG2=2, TIMEOUT=32.
module tb_als_sample_sequencer;
   localparam int P = 100;
   localparam int L = 2;
   localparam int T = 32;

   localparam logic [15:0] GOOD_FR [4] = '{16'h0FE0, 16'h0020, 16'h0100, 16'h0200};
   localparam logic [7:0]  GOOD_SM [4] = '{8'h7F, 8'h01, 8'h08, 8'h10};
   localparam logic [15:0] BLK2_FR [4] = '{16'h0200, 16'h0400, 16'h0600, 16'h0800};
   localparam logic [7:0]  BLK2_SM [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

   logic        clock = 1'b0;
   logic        reset, enable, clear_error, spi_busy, spi_done;
   logic [15:0] spi_frame;
   logic        spi_start, sample_valid, average_valid, frame_error, timeout_error, overrun;
   logic [7:0]  sample, average;

   int pass_cnt  = 0;
   int total_cnt = 0;

   als_sample_sequencer #(
      .PERIOD_CYCLES (P),
      .AVG_LOG2      (L),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .clear_error  (clear_error),
      .spi_start    (spi_start),
      .spi_busy     (spi_busy),
      .spi_done     (spi_done),
      .spi_frame    (spi_frame),
      .sample       (sample),
      .sample_valid (sample_valid),
      .average      (average),
      .average_valid(average_valid),
      .frame_error  (frame_error),
      .timeout_error(timeout_error),
      .overrun      (overrun)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Leaves the bench in cycle 0: reset just released, period timer at zero.
   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; clear_error = 1'b0;
      spi_busy = 1'b0; spi_done = 1'b0; spi_frame = '0;
      step();
      step();
      reset  = 1'b0;
      enable = 1'b1;
   endtask

   task automatic wait_start(input int max, output int n);
      n = 0;
      while (spi_start !== 1'b1 && n < max) begin
         step();
         n++;
      end
   endtask

   // Called in the spi_start cycle; returns in the cycle the results are visible.
   task automatic respond(input logic [15:0] fr, input int delay);
      repeat (delay) step();
      spi_done = 1'b1; spi_frame = fr;
      step();
      spi_done = 1'b0; spi_frame = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; clear_error = 1'b0;
      spi_busy = 1'b0; spi_done = 1'b1; spi_frame = 16'h0FE0;
      step();
      step();
      spi_done = 1'b0;
      total_cnt++;
      if ({sample, average, spi_start, sample_valid, average_valid, frame_error, timeout_error, overrun} !== 22'h0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {sample, average, spi_start, sample_valid, average_valid, frame_error, timeout_error, overrun});
      else pass_cnt++;
   endtask

   task automatic test_good_frames();
      int n;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wait_start(P + 5, n);
         total_cnt++;
         if (n !== ((i == 0) ? 100 : 79)) $display("FAIL good_start_delay[%0d]: got %0d expected %0d", i, n, (i == 0) ? 100 : 79);
         else pass_cnt++;
         respond(GOOD_FR[i], 20);
         total_cnt++;
         if (sample_valid !== 1'b1) $display("FAIL good_sample_valid[%0d]: got %b expected 1", i, sample_valid);
         else pass_cnt++;
         total_cnt++;
         if (sample !== GOOD_SM[i]) $display("FAIL good_sample[%0d]: got %h expected %h", i, sample, GOOD_SM[i]);
         else pass_cnt++;
         total_cnt++;
         if (frame_error !== 1'b0) $display("FAIL good_frame_error[%0d]: got %b expected 0", i, frame_error);
         else pass_cnt++;
         total_cnt++;
         if (average_valid !== (i == 3)) $display("FAIL good_average_valid[%0d]: got %b expected %b", i, average_valid, i == 3);
         else pass_cnt++;
         total_cnt++;
         if (average !== ((i == 3) ? 8'h26 : 8'h00)) $display("FAIL good_average[%0d]: got %h expected %h", i, average, (i == 3) ? 8'h26 : 8'h00);
         else pass_cnt++;
      end
      step();
      total_cnt++;
      if ({sample_valid, average_valid} !== 2'b00) $display("FAIL good_pulse_width: got %b expected 00", {sample_valid, average_valid});
      else pass_cnt++;
   endtask

   // Continues from test_good_frames, whose block has just completed.
   task automatic test_bad_frame();
      int n;
      wait_start(P + 5, n);
      respond(16'h8FE0, 20);
      total_cnt++;
      if (frame_error !== 1'b1) $display("FAIL bad_frame_error: got %b expected 1", frame_error);
      else pass_cnt++;
      total_cnt++;
      if (sample_valid !== 1'b0) $display("FAIL bad_sample_valid: got %b expected 0", sample_valid);
      else pass_cnt++;
      total_cnt++;
      if (sample !== 8'h10) $display("FAIL bad_sample_held: got %h expected 10", sample);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         wait_start(P + 5, n);
         total_cnt++;
         if (n !== 79) $display("FAIL bad_start_delay[%0d]: got %0d expected 79", i, n);
         else pass_cnt++;
         respond(BLK2_FR[i], 20);
         total_cnt++;
         if (sample !== BLK2_SM[i] || sample_valid !== 1'b1) $display("FAIL blk2_sample[%0d]: got %h/%b expected %h/1", i, sample, sample_valid, BLK2_SM[i]);
         else pass_cnt++;
         total_cnt++;
         if (average_valid !== (i == 3)) $display("FAIL blk2_average_valid[%0d]: got %b expected %b", i, average_valid, i == 3);
         else pass_cnt++;
         total_cnt++;
         if (average !== ((i == 3) ? 8'h28 : 8'h26)) $display("FAIL blk2_average[%0d]: got %h expected %h", i, average, (i == 3) ? 8'h28 : 8'h26);
         else pass_cnt++;
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      wait_start(P + 5, n);
      total_cnt++;
      if (n !== 100) $display("FAIL to_start_delay: got %0d expected 100", n);
      else pass_cnt++;
      // WAIT is entered one cycle after spi_start, so the flag shows 33 cycles after it.
      for (int k = 1; k <= 33; k++) begin
         step();
         total_cnt++;
         if (timeout_error !== (k == 33)) $display("FAIL to_flag[%0d]: got %b expected %b", k, timeout_error, k == 33);
         else pass_cnt++;
      end
      wait_start(P + 5, n);
      total_cnt++;
      if (n !== 67) $display("FAIL to_next_start: got %0d expected 67", n);
      else pass_cnt++;
      clear_error = 1'b1;
      step();
      clear_error = 1'b0;
      total_cnt++;
      if ({timeout_error, overrun} !== 2'b00) $display("FAIL to_clear: got %b expected 00", {timeout_error, overrun});
      else pass_cnt++;
   endtask

   task automatic test_busy_overrun();
      int pulses = 0;
      int first  = -1;
      do_reset();
      for (int c = 0; c < 299; c++) begin
         spi_busy = (c >= 90 && c < 240);
         if (spi_start === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
         end
         if (c == 199 || c == 200) begin
            total_cnt++;
            if (overrun !== (c == 200)) $display("FAIL busy_overrun[%0d]: got %b expected %b", c, overrun, c == 200);
            else pass_cnt++;
         end
         step();
      end
      spi_busy = 1'b0;
      total_cnt++;
      if (first !== 241) $display("FAIL busy_start_cycle: got %0d expected 241", first);
      else pass_cnt++;
      total_cnt++;
      if (pulses !== 1) $display("FAIL busy_pulse_count: got %0d expected 1", pulses);
      else pass_cnt++;
   endtask

   task automatic test_enable_off();
      int n;
      int pulses = 0;
      do_reset();
      wait_start(P + 5, n);
      repeat (5) step();
      enable = 1'b0;
      respond(16'h0FE0, 15);
      total_cnt++;
      if (sample_valid !== 1'b1 || sample !== 8'h7F) $display("FAIL en_off_sample: got %h/%b expected 7f/1", sample, sample_valid);
      else pass_cnt++;
      for (int c = 0; c < 300; c++) begin
         if (spi_start === 1'b1) pulses++;
         step();
      end
      total_cnt++;
      if (pulses !== 0) $display("FAIL en_off_starts: got %0d expected 0", pulses);
      else pass_cnt++;
      total_cnt++;
      if ({timeout_error, overrun} !== 2'b00) $display("FAIL en_off_flags: got %b expected 00", {timeout_error, overrun});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      wait_start(P + 5, n);
      respond(16'h0FE0, 20);
      wait_start(P + 5, n);
      repeat (40) step();
      total_cnt++;
      if (sample !== 8'h7F || timeout_error !== 1'b1) $display("FAIL rmid_precond: got %h/%b expected 7f/1", sample, timeout_error);
      else pass_cnt++;
      wait_start(P + 5, n);
      repeat (5) step();
      reset = 1'b1;
      step();
      total_cnt++;
      if ({sample, average, spi_start, sample_valid, average_valid, frame_error, timeout_error, overrun} !== 22'h0)
         $display("FAIL rmid_outputs: got %h expected 0",
                  {sample, average, spi_start, sample_valid, average_valid, frame_error, timeout_error, overrun});
      else pass_cnt++;
      reset = 1'b0;
      wait_start(P + 5, n);
      total_cnt++;
      if (n !== 100) $display("FAIL rmid_restart_delay: got %0d expected 100", n);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_good_frames();
      test_bad_frame();
      test_timeout();
      test_busy_overrun();
      test_enable_off();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
